// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// byte-enable patterns and request classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int unsigned TO_W = 8;

  // Unsigned loads have no store counterpart.
  function automatic logic f3_legal(input logic [2:0] f3, input logic wr);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~wr;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] f3_eff_off(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] eff;
    eff = off;
    case (f3)
      F3_H, F3_HU: eff = {off[1], 1'b0};
      F3_W:        eff = 2'b00;
      default:     eff = off;
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: req/ack handshake with byte enables.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data from the
// request, and lane select plus sign/zero extension of the returned word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = off[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = '0;
    case (func3)
      F3_B, F3_BU: begin
        be        = BE_BYTE << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (func3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      F3_H, F3_HU: begin
        be        = BE_HALF << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (func3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      F3_W: begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store per instruction, runs the req/ack memory
// port with timeout, extends load data. Optional MISALIGN_TRAP_EN traps misaligned H/W.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [2:0]         func3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic               done,
  output logic [31:0]        rdata,
  output logic               err,
  load_store_unit_if.master  mem
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  lsu_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            write_q, write_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic [1:0]  req_off;
  logic        trap;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

`ifdef MISALIGN_TRAP_EN
  assign req_off = addr[1:0];
  assign trap    = ~f3_legal(func3, req_write) | f3_misaligned(func3, addr[1:0]);
`else
  assign req_off = f3_eff_off(func3, addr[1:0]);
  assign trap    = ~f3_legal(func3, req_write);
`endif

  // One aligner serves both phases: request fields in IDLE, latched fields afterwards.
  assign al_f3  = (state_q == S_IDLE) ? func3   : f3_q;
  assign al_off = (state_q == S_IDLE) ? req_off : off_q;

  lsu_align u_align (
    .func3     (al_f3),
    .off       (al_off),
    .wdata     (wdata),
    .rword     (mem.mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    write_d     = write_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (trap) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = TO_W'(1);
            f3_d        = func3;
            off_d       = req_off;
            write_d     = req_write;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
          end
        end
      end
      S_WAIT: begin
        // cnt_q counts WAIT cycles from 1, so mem_req stays up exactly TIMEOUT_CYCLES cycles.
        if (mem.mem_ack) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          err_d     = 1'b0;
          rdata_d   = write_q ? '0 : al_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == TO_LIMIT) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      write_q     <= write_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign stall         = req_valid & ~done_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus random operations
// checked against an arithmetic reference model and a latency-controlled memory.
module tb_load_store_unit;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;

  int unsigned chk_cnt = 0;
  int unsigned err_cnt = 0;

  load_store_unit_if mif ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .func3     (func3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_model(
    input  logic [2:0]  f3,
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rword,
    output logic        trap,
    output logic [31:0] e_addr,
    output logic [3:0]  e_be,
    output logic [31:0] e_wdata,
    output logic [31:0] e_rdata
  );
    int unsigned size, off;
    bit legal, sgn;
    longint v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = (size != 0) && !(wr && f3[2]);
    sgn   = (f3 == 3'd0) || (f3 == 3'd1);
    off   = a % 4;
`ifdef MISALIGN_TRAP_EN
    trap = !legal || (size != 0 && (off % size) != 0);
`else
    trap = !legal;
    if (size != 0) off = off - (off % size);
`endif
    e_addr  = a - (a % 4);
    e_be    = legal ? 4'(((1 << size) - 1) << off) : 4'd0;
    e_wdata = (size == 1) ? (wd & 32'hff) * 32'h0101_0101 :
              (size == 2) ? (wd & 32'hffff) * 32'h0001_0001 : wd;
    v = (longint'(rword) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    e_rdata = (trap || wr) ? 32'd0 : 32'(v);
  endfunction

  // Called at a falling edge. lat = WAIT cycle in which memory acks; 0 = never.
  task automatic run_op(input logic [2:0] f3, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rword, input int unsigned lat);
    logic        trap;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    int unsigned n, nreq, nstall, exp_n, exp_req;
    bit          got_done, exp_err;
    ref_model(f3, wr, a, wd, rword, trap, e_addr, e_be, e_wdata, e_rdata);
    exp_err = trap || (lat == 0);
    exp_n   = trap ? 1 : (lat == 0 ? TO + 1 : lat + 1);
    exp_req = trap ? 0 : exp_n - 1;
    if (exp_err) e_rdata = 32'd0;

    req_valid     = 1'b1;
    req_write     = wr;
    func3         = f3;
    addr          = a;
    wdata         = wd;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = $urandom;
    n = 0; nreq = 0; nstall = 0; got_done = 1'b0;
    #1;
    if (stall) nstall++;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = $urandom;
      if (stall) nstall++;
      if (mif.mem_req) begin
        nreq++;
        check("mem_addr", mif.mem_addr, e_addr);
        check("mem_be", 32'(mif.mem_be), 32'(e_be));
        check("mem_wdata", mif.mem_wdata, e_wdata);
        check("mem_we", 32'(mif.mem_we), 32'(wr));
        if (nreq == lat) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = rword;
        end
      end
      if (done) begin
        got_done = 1'b1;
        check("rdata", rdata, e_rdata);
        check("err", 32'(err), 32'(exp_err));
      end
    end
    if (!got_done) check("done_seen", 32'd0, 32'd1);
    check("done_latency", 32'(n), 32'(exp_n));
    check("req_cycles", 32'(nreq), 32'(exp_req));
    check("stall_cycles", 32'(nstall), 32'(exp_n));

    // Stray ack while idle must not start anything.
    req_valid     = 1'b0;
    mif.mem_ack   = 1'($urandom_range(0, 1));
    mif.mem_rdata = $urandom;
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_req", 32'(mif.mem_req), 32'd0);
    mif.mem_ack = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; func3 = '0; addr = '0; wdata = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    #3;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_req", 32'(mif.mem_req), 32'd0);
    check("rst_mem_be", 32'(mif.mem_be), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'b000, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);   // LB sign-extend, lane 3
    run_op(3'b001, 1'b1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 2);   // SH upper half
    run_op(3'b101, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_F00D, 5);   // LHU slow ack
    run_op(3'b010, 1'b0, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 0);   // LW timeout
    run_op(3'b010, 1'b0, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 1);   // LW misaligned
    run_op(3'b001, 1'b0, 32'h0000_0207, 32'h0, 32'h8001_7FFE, 3);   // LH misaligned
    run_op(3'b011, 1'b0, 32'h0000_0010, 32'h0, 32'h1111_1111, 1);   // illegal func3
    run_op(3'b100, 1'b1, 32'h0000_0011, 32'h55, 32'h0, 1);          // BU store illegal
    run_op(3'b010, 1'b1, 32'h0000_0400, 32'h89AB_CDEF, 32'h0, 1);   // SW

    // Reset in the middle of a WAIT.
    req_valid = 1'b1; req_write = 1'b0; func3 = 3'b010; addr = 32'h80; wdata = '0;
    mif.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_req", 32'(mif.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_req", 32'(mif.mem_req), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_we", 32'(mif.mem_we), 32'd0);
    req_valid = 1'b0;
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'b010, 1'b0, 32'h0000_0084, 32'h0, 32'h0, 0);           // counter restarts after reset
    run_op(3'b100, 1'b0, 32'h0000_0086, 32'h0, 32'h00AB_0000, 1);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom, $urandom_range(1, 6));
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
